// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU op sequencer: ALU mode encodings, the program word
// layout and the sequencer state encoding.
package alu_seq_pkg;

    localparam int SEQ_DW = 4;
    localparam int SEQ_MW = 3;
    localparam int SEQ_PW = SEQ_MW + 1 + SEQ_DW;

    // Mode-select encodings understood by the downstream registered ALU
    typedef enum logic [SEQ_MW-1:0] {
        NOT_A   = 3'b000,
        ADD_ABC = 3'b001,
        AND_AB  = 3'b010,
        OR_AB   = 3'b011,
        XOR_AB  = 3'b100,
        ROT_AC  = 3'b101,
        ZERO    = 3'b110,
        ONE     = 3'b111
    } alu_mode_e;

    // One program word: operation, stop-after-this flag, immediate B operand
    typedef struct packed {
        alu_mode_e          mode;
        logic               halt;
        logic [SEQ_DW-1:0]  imm;
    } prog_word_t;

    // Sequencer control states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } seq_state_e;

    // Builds a program word from its fields
    function automatic prog_word_t make_word(input alu_mode_e mode,
                                             input logic halt,
                                             input logic [SEQ_DW-1:0] imm);
        prog_word_t w;
        w.mode = mode;
        w.halt = halt;
        w.imm  = imm;
        return w;
    endfunction

endpackage

// File: rtl/alu_prog_mem.sv
// Program store for the sequencer: register file with one synchronous write
// port and one combinational read port. Contents are deliberately not reset
// so a program survives a reset of the control logic.
module alu_prog_mem #(
    parameter int DEPTH = 16,
    parameter int PW    = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [PW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [PW-1:0] rdata
);

    logic [PW-1:0] mem [DEPTH];

    // Write port: one word per clock when enabled
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/alu_op_sequencer.sv
// Upstream control stage for the registered 4-bit ALU. Issues one program
// word at a time, waits one cycle for the registered result, then folds the
// result and carry-out back in as the next A operand and C input.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int DW    = 4,
    parameter int MW    = 3,
    localparam int AW   = $clog2(DEPTH),
    localparam int PW   = MW + 1 + DW
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [PW-1:0] prog_data,
    input  logic          start,
    input  logic [DW-1:0] init_acc,
    input  logic          init_carry,
    input  logic          abort,
    output logic [MW-1:0] alu_mode,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic          alu_c,
    input  logic [DW-1:0] alu_result,
    input  logic          alu_cout,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] acc_out,
    output logic          carry_out,
    output logic [AW-1:0] pc,
    output logic          prog_err
);

    seq_state_e    state;
    seq_state_e    state_next;

    logic [AW-1:0] pc_q;
    logic [DW-1:0] acc_q;
    logic          carry_q;
    logic [MW-1:0] mode_q;
    logic [DW-1:0] imm_q;
    logic          prog_err_q;

    logic [PW-1:0] rd_word;
    logic [MW-1:0] cur_mode;
    logic          cur_halt;
    logic [DW-1:0] cur_imm;
    logic          pc_last;
    logic          in_idle;
    logic          start_ok;
    logic          mem_we;

    // Program writes only land while idle; a write to word 0 on the start
    // edge is still seen by the first issue because the read is combinational.
    assign in_idle  = (state == IDLE);
    assign start_ok = in_idle && start;
    assign mem_we   = in_idle && prog_we;

    alu_prog_mem #(
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_prog_mem (
        .clock (clock),
        .we    (mem_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (pc_q),
        .rdata (rd_word)
    );

    assign cur_mode = rd_word[PW-1 -: MW];
    assign cur_halt = rd_word[DW];
    assign cur_imm  = rd_word[DW-1:0];
    assign pc_last  = (pc_q == AW'(DEPTH - 1));

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; abort wins over halt and end-of-memory
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                state_next = abort ? DONE : CAPTURE;
            end
            CAPTURE: begin
                if (abort || cur_halt || pc_last) begin
                    state_next = DONE;
                end else begin
                    state_next = ISSUE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Program counter, accumulator and carry: loaded at start, updated only
    // by a non-aborted capture; pc stops on the last word instead of wrapping
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q    <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pc_q    <= '0;
                        acc_q   <= init_acc;
                        carry_q <= init_carry;
                    end
                end
                CAPTURE: begin
                    if (!abort) begin
                        acc_q   <= alu_result;
                        carry_q <= alu_cout;
                        if (!cur_halt && !pc_last) begin
                            pc_q <= pc_q + AW'(1);
                        end
                    end
                end
                default: begin
                    pc_q <= pc_q;
                end
            endcase
        end
    end

    // Remember the last issued mode and immediate so the ALU inputs stay
    // put outside the issue cycle even if pc or memory contents move on
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mode_q <= '0;
            imm_q  <= '0;
        end else if (state == ISSUE) begin
            mode_q <= cur_mode;
            imm_q  <= cur_imm;
        end
    end

    // Sticky error for program writes attempted mid-run; an accepted start clears it
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prog_err_q <= 1'b0;
        end else if (start_ok) begin
            prog_err_q <= 1'b0;
        end else if (prog_we && !in_idle) begin
            prog_err_q <= 1'b1;
        end
    end

    assign alu_mode  = (state == ISSUE) ? cur_mode : mode_q;
    assign alu_b     = (state == ISSUE) ? cur_imm  : imm_q;
    assign alu_a     = acc_q;
    assign alu_c     = carry_q;

    assign busy      = !in_idle;
    assign done      = (state == DONE);
    assign acc_out   = acc_q;
    assign carry_out = carry_q;
    assign pc        = pc_q;
    assign prog_err  = prog_err_q;

endmodule
